// File: rtl/mw_pipe_reg.sv
// MEM->WB pipeline stage register: valid/ready handshake with a 2-entry skid
// buffer, flush, write-enable gating and a saturating stall counter.
module mw_pipe_reg #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_data,
  input  logic [REG_AW-1:0] Rd,
  input  logic              RdEn,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] mem_data_wb,
  output logic [REG_AW-1:0] Rd_wb,
  output logic              RdEn_wb,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] m_data, s_data;
  logic [REG_AW-1:0] m_rd, s_rd;
  logic              m_en, s_en;
  logic              accept, pop;
  logic              load_m_in, load_m_skid, load_s;

  assign out_valid   = (state != EMPTY);
  assign in_ready    = (state != TWO);
  assign occupancy   = state;
  assign mem_data_wb = m_data;
  assign Rd_wb       = m_rd;
  assign RdEn_wb     = out_valid & m_en;

  assign accept = in_valid & in_ready;
  assign pop    = out_valid & out_ready;

  always_comb begin
    state_nxt   = state;
    load_m_in   = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    case (state)
      EMPTY: begin
        if (accept) begin
          load_m_in = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        if (accept && pop) begin
          load_m_in = 1'b1;
        end else if (accept) begin
          load_s    = 1'b1;
          state_nxt = TWO;
        end else if (pop) begin
          state_nxt = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          load_m_skid = 1'b1;
          state_nxt   = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)        state <= EMPTY;
    else if (flush) state <= EMPTY;
    else            state <= state_nxt;
  end

  // Payload holds across flush; out_valid=0 hides it.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data <= '0;
      m_rd   <= '0;
      m_en   <= 1'b0;
      s_data <= '0;
      s_rd   <= '0;
      s_en   <= 1'b0;
    end else if (!flush) begin
      if (load_m_in) begin
        m_data <= mem_data;
        m_rd   <= Rd;
        m_en   <= RdEn;
      end else if (load_m_skid) begin
        m_data <= s_data;
        m_rd   <= s_rd;
        m_en   <= s_en;
      end
      if (load_s) begin
        s_data <= mem_data;
        s_rd   <= Rd;
        s_en   <= RdEn;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != CNT_MAX)
      stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: doc/mw_pipe_reg.md
Name: mw_pipe_reg

Overview:
- Parametrised MEM->WB pipeline stage register. Next generation of the fixed 32/4/1-bit MEM/WB latch.
- Adds valid/ready handshake, a 2-entry skid buffer (full throughput under backpressure), flush, write-enable gating and a saturating stall counter.
- Sits between the memory stage and register-file writeback.

Parameters:
- DATA_W, 32: width of the load/ALU result payload.
- REG_AW, 4: width of the destination register index.
- CNT_W, 16: width of the stall counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- flush, input, 1: synchronous pipeline flush; drops all held entries.
- in_valid, input, 1: upstream entry present.
- in_ready, output, 1: stage can accept an entry this cycle.
- mem_data, input, DATA_W: upstream result data.
- Rd, input, REG_AW: upstream destination register.
- RdEn, input, 1: upstream register-write enable.
- out_valid, output, 1: main entry valid toward writeback.
- out_ready, input, 1: writeback consumes the main entry this cycle.
- mem_data_wb, output, DATA_W: main entry data.
- Rd_wb, output, REG_AW: main entry destination.
- RdEn_wb, output, 1: equals out_valid AND main-entry RdEn.
- occupancy, output, 2: number of held entries, 0..2.
- stall_cnt, output, CNT_W: saturating count of stalled cycles.

Behaviour:
- Storage:
  - Main register M (data, Rd, RdEn) drives the *_wb outputs.
  - Skid register S has the same fields.
- States:
  - EMPTY: M invalid.
  - ONE: M valid, S empty.
  - TWO: M and S both valid.
- Encoding:
  - occupancy = 0 / 1 / 2 for EMPTY / ONE / TWO.
  - out_valid = (state != EMPTY).
- in_ready = (state != TWO). It is registered state, not combinational on out_ready.
- Accept means in_valid & in_ready. Pop means out_valid & out_ready.
- Transitions when neither rst nor flush is active:
  - EMPTY: accept -> M<=in, ONE. Otherwise stay.
  - ONE, accept & pop -> M<=in, stay ONE (full throughput).
  - ONE, accept & !pop -> S<=in, TWO.
  - ONE, !accept & pop -> EMPTY.
  - ONE, otherwise -> hold.
  - TWO: pop -> M<=S, ONE. No input is accepted in TWO. Otherwise hold.
- Ordering: strict FIFO. The S entry always leaves after the M entry.
- Latency: an entry accepted in cycle N appears on the outputs in cycle N+1 when the stage was EMPTY or popping.
- Reset (rst=1):
  - state EMPTY.
  - M, S and stall_cnt cleared to 0.
  - Outputs: out_valid=0, RdEn_wb=0, mem_data_wb=0, Rd_wb=0, in_ready=1, occupancy=0, stall_cnt=0.
  - rst has priority over flush and over all handshake inputs.
- Flush (flush=1, rst=0):
  - state becomes EMPTY next cycle and any same-cycle input is dropped.
  - M/S payload registers hold their value; their visibility is suppressed because RdEn_wb = 0 when out_valid = 0.
  - stall_cnt is not affected.
  - Flush in the same cycle as a pop: the pop is counted as consumed by the downstream stage, and the stage still ends EMPTY.
- RdEn_wb gating: RdEn_wb is never 1 while out_valid = 0, in all states including after flush.
- Entries with RdEn=0 still occupy a slot and flow normally.
- stall_cnt:
  - Increments by 1 each cycle with out_valid & !out_ready.
  - Saturates at 2^CNT_W-1; no wrap.
  - Cleared only by rst.
- Combinational paths: none from inputs to outputs. Every output is a register, or simple logic of registers.

Test Plan:
- Reset: drive in_valid=1 during rst -> after release: out_valid=0, in_ready=1, occupancy=0, stall_cnt=0, mem_data_wb=0.
- Streaming: out_ready=1, back-to-back entries 0xA0..0xA7 with Rd=1..8 -> each appears 1 cycle later, in order, occupancy stays <=1, stall_cnt=0.
- Skid fill:
  - Accept 0x11, then hold out_ready=0 and accept 0x22 -> occupancy=2, in_ready=0, and 0x33 offered is not taken.
  - Raise out_ready -> outputs 0x11, then 0x22, then 0x33 after it is re-accepted.
- Flush:
  - With occupancy=2, assert flush together with in_valid (0x44) -> next cycle: out_valid=0, RdEn_wb=0, in_ready=1, occupancy=0.
  - 0x44 never appears on the outputs.
- Write gating: entry with RdEn=0, Rd=5 -> out_valid=1, RdEn_wb=0. Entry with RdEn=1 -> RdEn_wb=1 only while out_valid=1.
- Stall counter (CNT_W=3): hold a valid entry with out_ready=0 for 10 cycles -> stall_cnt reads 1..7, then stays at 7. rst returns it to 0.
